bfm_apb2apb_bridge: RTL and testbench



---
 rtl/bfm_apb_pkg.sv | 22 ++
 rtl/bfm_apb_wait_timer.sv | 29 ++
 rtl/bfm_apb2apb_bridge.sv | 211 +++++++++++++++++++++
 tb/tb_bfm_apb2apb_bridge.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bfm_apb_pkg.sv
// Shared types and constants for the BFM APB-to-APB bridge.
// The FSM state encoding and the error-counter helper live here so the top and sub-module agree.
package bfm_apb_pkg;

    localparam int SEL_W    = 4;
    localparam int ERRCNT_W = 8;

    localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    // Saturating increment: the counter sticks at its maximum instead of wrapping.
    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] value);
        return (value == ERRCNT_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/bfm_apb_wait_timer.sv
// 16-bit wait-state counter for the ACCESS phase of the bridge.
// expired flags the last allowed wait cycle; it is constant 0 when TIMEOUT is 0.
module bfm_apb_wait_timer #(
    parameter int TIMEOUT = 256
) (
    input  logic PCLK,
    input  logic PRESETN,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LAST_WAIT = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    logic [15:0] wait_cnt;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (enable) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign expired = (TIMEOUT != 0) && (wait_cnt == LAST_WAIT);

endmodule

// File: rtl/bfm_apb2apb_bridge.sv
// Single-clock APB-to-APB bridge: one master transfer at a time is re-issued on a decoded slave port,
// with an error response for unmapped selects, a PREADY timeout and a saturating error counter.
module bfm_apb2apb_bridge
    import bfm_apb_pkg::*;
#(
    parameter int TPD     = 1,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NSEL    = 16,
    parameter int SEL_LSB = 24,
    parameter int TIMEOUT = 256
) (
    input  logic                PCLK,
    input  logic                PRESETN,

    input  logic                PSEL_PM,
    input  logic [ADDR_W-1:0]   PADDR_PM,
    input  logic                PWRITE_PM,
    input  logic                PENABLE_PM,
    input  logic [DATA_W-1:0]   PWDATA_PM,
    output logic [DATA_W-1:0]   PRDATA_PM,
    output logic                PREADY_PM,
    output logic                PSLVERR_PM,

    output logic [NSEL-1:0]     PSEL_SC,
    output logic [ADDR_W-1:0]   PADDR_SC,
    output logic                PWRITE_SC,
    output logic                PENABLE_SC,
    output logic [DATA_W-1:0]   PWDATA_SC,
    input  logic [DATA_W-1:0]   PRDATA_SC,
    input  logic                PREADY_SC,
    input  logic                PSLVERR_SC,

    output logic [ERRCNT_W-1:0] ERRCNT
);

    // TPD only shapes simulation timing in the BFM library; the registered outputs here carry no delay.
    if (ADDR_W < 8 || ADDR_W > 32 || (DATA_W != 8 && DATA_W != 16 && DATA_W != 32) ||
        NSEL < 1 || NSEL > 16 || SEL_LSB < 0 || SEL_LSB + 3 >= ADDR_W ||
        TIMEOUT < 0 || TIMEOUT > 65535 || TPD < 0) begin : g_bad_params
        $error("bfm_apb2apb_bridge: unsupported parameter combination");
    end

    localparam logic [SEL_W:0] NSEL_LIM = (SEL_W + 1)'(NSEL);

    apb_state_t          state;
    apb_state_t          state_next;

    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;
    logic                cap_write;

    logic                trigger;
    logic [SEL_W-1:0]    in_idx;
    logic                in_mapped;
    logic                expired;

    logic                resp_err_d;
    logic [DATA_W-1:0]   resp_rdata_d;

    logic [ADDR_W-1:0]   pay_addr;
    logic [DATA_W-1:0]   pay_wdata;
    logic                pay_write;
    logic [SEL_W-1:0]    pay_idx;

    logic [NSEL-1:0]     psel_d;
    logic [ADDR_W-1:0]   paddr_d;
    logic                pwrite_d;
    logic                penable_d;
    logic [DATA_W-1:0]   pwdata_d;
    logic [DATA_W-1:0]   prdata_d;
    logic                pready_d;
    logic                pslverr_d;
    logic [ERRCNT_W-1:0] errcnt_d;

    assign trigger   = PSEL_PM && PENABLE_PM;
    assign in_idx    = PADDR_PM[SEL_LSB +: SEL_W];
    assign in_mapped = ({1'b0, in_idx} < NSEL_LIM);

    bfm_apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .clear   (state == SETUP),
        .enable  ((state == ACCESS) && !PREADY_SC),
        .expired (expired)
    );

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the response that accompanies any entry into RESP.
    always_comb begin
        state_next   = state;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    if (in_mapped) begin
                        state_next = SETUP;
                    end else begin
                        state_next = RESP;
                        resp_err_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (PREADY_SC) begin
                    state_next   = RESP;
                    resp_rdata_d = PRDATA_SC;
                    resp_err_d   = PSLVERR_SC;
                end else if (expired) begin
                    state_next = RESP;
                    resp_err_d = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_write <= 1'b0;
        end else if ((state == IDLE) && trigger) begin
            cap_addr  <= PADDR_PM;
            cap_wdata <= PWDATA_PM;
            cap_write <= PWRITE_PM;
        end
    end

    // Outputs are registered from the upcoming state, so SETUP drives the slave straight from the master bus.
    assign pay_addr  = (state == IDLE) ? PADDR_PM  : cap_addr;
    assign pay_wdata = (state == IDLE) ? PWDATA_PM : cap_wdata;
    assign pay_write = (state == IDLE) ? PWRITE_PM : cap_write;
    assign pay_idx   = pay_addr[SEL_LSB +: SEL_W];

    always_comb begin
        psel_d    = '0;
        paddr_d   = '0;
        pwrite_d  = 1'b0;
        penable_d = 1'b0;
        pwdata_d  = '0;
        prdata_d  = PRDATA_PM;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        errcnt_d  = ERRCNT;
        case (state_next)
            SETUP, ACCESS: begin
                for (int i = 0; i < NSEL; i++) begin
                    psel_d[i] = (pay_idx == SEL_W'(i));
                end
                paddr_d   = pay_addr;
                pwrite_d  = pay_write;
                pwdata_d  = pay_wdata;
                penable_d = (state_next == ACCESS);
            end
            RESP: begin
                pready_d  = 1'b1;
                pslverr_d = resp_err_d;
                prdata_d  = resp_rdata_d;
                if (resp_err_d) begin
                    errcnt_d = sat_inc(ERRCNT);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            PSEL_SC    <= '0;
            PADDR_SC   <= '0;
            PWRITE_SC  <= 1'b0;
            PENABLE_SC <= 1'b0;
            PWDATA_SC  <= '0;
            PRDATA_PM  <= '0;
            PREADY_PM  <= 1'b0;
            PSLVERR_PM <= 1'b0;
            ERRCNT     <= '0;
        end else begin
            PSEL_SC    <= psel_d;
            PADDR_SC   <= paddr_d;
            PWRITE_SC  <= pwrite_d;
            PENABLE_SC <= penable_d;
            PWDATA_SC  <= pwdata_d;
            PRDATA_PM  <= prdata_d;
            PREADY_PM  <= pready_d;
            PSLVERR_PM <= pslverr_d;
            ERRCNT     <= errcnt_d;
        end
    end

endmodule

// File: tb/tb_bfm_apb2apb_bridge.sv
// Directed and randomized bench for bfm_apb2apb_bridge with NSEL=4 and TIMEOUT=8.
// Expected timing and responses come from a transfer-level model of the bridge's rules.
module tb_bfm_apb2apb_bridge;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int NSEL    = 4;
    localparam int SEL_LSB = 24;
    localparam int TIMEOUT = 8;
    localparam int NEVER   = 1000;

    logic              PCLK;
    logic              PRESETN;
    logic              PSEL_PM;
    logic [ADDR_W-1:0] PADDR_PM;
    logic              PWRITE_PM;
    logic              PENABLE_PM;
    logic [DATA_W-1:0] PWDATA_PM;
    logic [DATA_W-1:0] PRDATA_PM;
    logic              PREADY_PM;
    logic              PSLVERR_PM;
    logic [NSEL-1:0]   PSEL_SC;
    logic [ADDR_W-1:0] PADDR_SC;
    logic              PWRITE_SC;
    logic              PENABLE_SC;
    logic [DATA_W-1:0] PWDATA_SC;
    logic [DATA_W-1:0] PRDATA_SC;
    logic              PREADY_SC;
    logic              PSLVERR_SC;
    logic [7:0]        ERRCNT;

    int n_asserts = 0;
    int n_fails   = 0;
    int model_errcnt = 0;
    logic [31:0] model_prdata = '0;

    bfm_apb2apb_bridge #(
        .TPD     (1),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NSEL    (NSEL),
        .SEL_LSB (SEL_LSB),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PCLK       (PCLK),
        .PRESETN    (PRESETN),
        .PSEL_PM    (PSEL_PM),
        .PADDR_PM   (PADDR_PM),
        .PWRITE_PM  (PWRITE_PM),
        .PENABLE_PM (PENABLE_PM),
        .PWDATA_PM  (PWDATA_PM),
        .PRDATA_PM  (PRDATA_PM),
        .PREADY_PM  (PREADY_PM),
        .PSLVERR_PM (PSLVERR_PM),
        .PSEL_SC    (PSEL_SC),
        .PADDR_SC   (PADDR_SC),
        .PWRITE_SC  (PWRITE_SC),
        .PENABLE_SC (PENABLE_SC),
        .PWDATA_SC  (PWDATA_SC),
        .PRDATA_SC  (PRDATA_SC),
        .PREADY_SC  (PREADY_SC),
        .PSLVERR_SC (PSLVERR_SC),
        .ERRCNT     (ERRCNT)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, " PSEL_SC"},    PSEL_SC,    '0);
        check_output({tag, " PENABLE_SC"}, PENABLE_SC, '0);
        check_output({tag, " PADDR_SC"},   PADDR_SC,   '0);
        check_output({tag, " PWDATA_SC"},  PWDATA_SC,  '0);
        check_output({tag, " PWRITE_SC"},  PWRITE_SC,  '0);
        check_output({tag, " PREADY_PM"},  PREADY_PM,  '0);
        check_output({tag, " PSLVERR_PM"}, PSLVERR_PM, '0);
        check_output({tag, " PRDATA_PM"},  PRDATA_PM,  model_prdata);
        check_output({tag, " ERRCNT"},     ERRCNT,     32'(model_errcnt));
    endtask

    // One complete master transfer; called and returns at a negedge. waits = slave wait states.
    task automatic apply_stimulus(input string tag, input logic [31:0] addr, input bit write,
                                  input logic [31:0] wdata, input int waits,
                                  input logic [31:0] srdata, input bit serr);
        int          idx;
        bit          mapped;
        int          k_done;
        bit          exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_sel;
        bit          busy;
        int          acc_seen;

        idx     = int'(addr[SEL_LSB +: 4]);
        mapped  = (idx < NSEL);
        exp_sel = 32'd1 << idx;
        if (!mapped) begin
            k_done = 0;  exp_err = 1'b1; exp_rdata = '0;
        end else if (waits <= TIMEOUT - 1) begin
            k_done = 2 + waits; exp_err = serr; exp_rdata = srdata;
        end else begin
            k_done = 1 + TIMEOUT; exp_err = 1'b1; exp_rdata = '0;
        end

        PSEL_PM    = 1'b1;
        PENABLE_PM = 1'b0;
        PADDR_PM   = addr;
        PWRITE_PM  = write;
        PWDATA_PM  = wdata;
        @(negedge PCLK);
        PENABLE_PM = 1'b1;
        acc_seen   = 0;

        for (int k = 0; k <= k_done + 1; k++) begin
            @(negedge PCLK);
            busy = mapped && (k < k_done);
            if (k == k_done) begin
                if (exp_err && model_errcnt < 255) model_errcnt++;
                model_prdata = exp_rdata;
            end
            check_output({tag, " PREADY_PM"},  PREADY_PM,  (k == k_done));
            check_output({tag, " PSLVERR_PM"}, PSLVERR_PM, (k == k_done) && exp_err);
            check_output({tag, " PRDATA_PM"},  PRDATA_PM,  model_prdata);
            check_output({tag, " ERRCNT"},     ERRCNT,     32'(model_errcnt));
            check_output({tag, " PSEL_SC"},    PSEL_SC,    busy ? exp_sel : 32'd0);
            check_output({tag, " PENABLE_SC"}, PENABLE_SC, busy && (k >= 1));
            check_output({tag, " PADDR_SC"},   PADDR_SC,   busy ? addr : 32'd0);
            check_output({tag, " PWDATA_SC"},  PWDATA_SC,  busy ? wdata : 32'd0);
            check_output({tag, " PWRITE_SC"},  PWRITE_SC,  busy && write);

            if (PENABLE_SC && (PSEL_SC != '0)) begin
                if (acc_seen == waits) begin
                    PREADY_SC  = 1'b1;
                    PRDATA_SC  = srdata;
                    PSLVERR_SC = serr;
                end else begin
                    PREADY_SC  = 1'b0;
                    PRDATA_SC  = $urandom;
                    PSLVERR_SC = 1'($urandom);
                end
                acc_seen++;
            end else begin
                PREADY_SC  = 1'b0;
                PRDATA_SC  = $urandom;
                PSLVERR_SC = 1'($urandom);
            end

            if (k == k_done + 1) begin
                PSEL_PM    = 1'b0;
                PENABLE_PM = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] addr;
        PRESETN    = 1'b1;
        PSEL_PM    = 1'b0;
        PENABLE_PM = 1'b0;
        PADDR_PM   = '0;
        PWRITE_PM  = 1'b0;
        PWDATA_PM  = '0;
        PRDATA_SC  = '0;
        PREADY_SC  = 1'b0;
        PSLVERR_SC = 1'b0;
        #1 PRESETN = 1'b0;
        #1 check_idle("reset");
        @(negedge PCLK);
        @(negedge PCLK);
        PRESETN = 1'b1;
        @(negedge PCLK);
        check_idle("post_reset");

        $display("[TB] directed transfers");
        apply_stimulus("wr_zero_wait", 32'h0300_0010, 1'b1, 32'hCAFE_F00D, 0, 32'h0BAD_BEEF, 1'b0);
        apply_stimulus("rd_4_waits",   32'h0200_0100, 1'b0, 32'h0,         4, 32'h1234_5678, 1'b0);
        apply_stimulus("unmapped",     32'h0500_0000, 1'b0, 32'h0,         0, 32'h5555_5555, 1'b0);
        apply_stimulus("slave_err",    32'h0100_0004, 1'b1, 32'hA5A5_0001, 2, 32'h0000_00EE, 1'b1);
        apply_stimulus("timeout",      32'h0000_0020, 1'b0, 32'h0,     NEVER, 32'h7777_7777, 1'b0);
        apply_stimulus("ready_at_tmo", 32'h0300_0030, 1'b0, 32'h0, TIMEOUT-1, 32'h8765_4321, 1'b0);
        apply_stimulus("tmo_plus_one", 32'h0200_0030, 1'b0, 32'h0,   TIMEOUT, 32'h1111_2222, 1'b0);

        $display("[TB] reset during ACCESS");
        PSEL_PM    = 1'b1;
        PENABLE_PM = 1'b0;
        PADDR_PM   = 32'h0100_0008;
        PWRITE_PM  = 1'b1;
        PWDATA_PM  = 32'hDEAD_0001;
        @(negedge PCLK);
        PENABLE_PM = 1'b1;
        @(negedge PCLK);
        @(negedge PCLK);
        check_output("rst_mid PENABLE_SC before", PENABLE_SC, 1'b1);
        check_output("rst_mid ERRCNT before",     ERRCNT,     32'(model_errcnt));
        #2 PRESETN = 1'b0;
        model_errcnt = 0;
        model_prdata = '0;
        #1 check_idle("rst_mid async");
        PSEL_PM    = 1'b0;
        PENABLE_PM = 1'b0;
        @(negedge PCLK);
        check_idle("rst_mid held");
        PRESETN = 1'b1;
        @(negedge PCLK);
        check_idle("rst_mid released");
        apply_stimulus("after_reset", 32'h0100_0008, 1'b0, 32'h0, 1, 32'hFEED_FACE, 1'b0);

        $display("[TB] back-to-back writes");
        apply_stimulus("b2b_first",  32'h0000_0044, 1'b1, 32'h0000_1111, 0, 32'h0, 1'b0);
        apply_stimulus("b2b_second", 32'h0300_0048, 1'b1, 32'h0000_2222, 0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            check_idle("b2b_no_third");
        end

        $display("[TB] randomized transfers");
        for (int i = 0; i < 60; i++) begin
            addr = $urandom;
            apply_stimulus("random", addr, 1'($urandom), $urandom, int'($urandom_range(0, 10)),
                           $urandom, 1'($urandom));
        end

        $display("[TB] error counter saturation");
        for (int i = 0; i < 300; i++) begin
            addr = $urandom;
            addr[SEL_LSB +: 4] = 4'($urandom_range(NSEL, 15));
            apply_stimulus("saturate", addr, 1'($urandom), $urandom, 0, $urandom, 1'b0);
        end
        check_output("saturate final ERRCNT", ERRCNT, 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
